serial_frame_rx: RTL and testbench

- Serial-to-parallel frame receiver. Sits directly downstream of the single-bit positive-edge D flip-flop stage and consumes its registered q output as a serial bit stream.
- Detects a start bit, shifts in DATA_W data bits MSB-first, and checks a stop bit.
- Presents each complete word on a valid/ready output port.
- Flags framing errors and overruns.

---
 rtl/serial_frame_rx.sv | 100 ++++++++++
 tb/tb_serial_frame_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial start/data/stop frame receiver with valid/ready word output
module serial_frame_rx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d,
   input  logic              en,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   input  logic              ready,
   output logic              frame_err,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
   logic [DATA_W-1:0]   shift_q, shift_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic                valid_nxt;
   logic                frame_err_nxt;
   logic                overrun_nxt;

   // State, counter, holding register and flag pulses update together on each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_q   <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_q   <= shift_nxt;
         data_out  <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= frame_err_nxt;
         overrun   <= overrun_nxt;
      end
   end

   // Frame sequencing on enabled bits; the handshake runs every cycle regardless of en.
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift_q;
      data_nxt      = data_out;
      valid_nxt     = valid & ~ready;
      frame_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (d) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
               end
            end
            DATA: begin
               shift_nxt = {shift_q[DATA_W-2:0], d};
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  state_nxt   = STOP;
                  bit_cnt_nxt = CNT_W'(DATA_W);
               end else begin
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               // A high stop bit ends the frame; it is never reused as a start bit.
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
               if (d) begin
                  frame_err_nxt = 1'b1;
               end else if (!valid || ready) begin
                  data_nxt  = shift_q;
                  valid_nxt = 1'b1;
               end else begin
                  overrun_nxt = 1'b1;
               end
            end
            default: begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - randomized and directed bench for serial_frame_rx against a frame-level model
module tb_serial_frame_rx;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          d;
   logic          en;
   logic          ready;
   logic [DW-1:0] data_out;
   logic          valid;
   logic          frame_err;
   logic          overrun;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: received bits of the current frame, plus expected outputs.
   int            rxq[$];
   logic [DW-1:0] m_data  = '0;
   logic          m_valid = 1'b0;
   logic          m_ferr  = 1'b0;
   logic          m_ovr   = 1'b0;

   serial_frame_rx #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .d         (d),
      .en        (en),
      .data_out  (data_out),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs applied before it.
   task automatic model_edge(input logic r, input logic b, input logic e, input logic rd);
      logic          old_valid;
      logic [DW-1:0] word;
      if (r) begin
         rxq.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_ferr  = 1'b0;
         m_ovr   = 1'b0;
         return;
      end
      old_valid = m_valid;
      m_ferr    = 1'b0;
      m_ovr     = 1'b0;
      if (m_valid && rd) m_valid = 1'b0;
      if (e) begin
         if (rxq.size() == 0) begin
            if (b) rxq.push_back(1);
         end else begin
            rxq.push_back(int'(b));
            if (rxq.size() == DW + 2) begin
               if (b) begin
                  m_ferr = 1'b1;
               end else begin
                  word = '0;
                  for (int i = 1; i <= DW; i++) word = {word[DW-2:0], rxq[i][0]};
                  if (!old_valid || rd) begin
                     m_data  = word;
                     m_valid = 1'b1;
                  end else begin
                     m_ovr = 1'b1;
                  end
               end
               rxq.delete();
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic b, input logic e, input logic rd);
      rst   = r;
      d     = b;
      en    = e;
      ready = rd;
      @(posedge clk);
      model_edge(r, b, e, rd);
      #1;
      check("data_out",  32'(data_out),  32'(m_data));
      check("valid",     32'(valid),     32'(m_valid));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun",   32'(overrun),   32'(m_ovr));
      check("exclusive", 32'(frame_err & overrun), 32'(0));
   endtask

   // One frame; rnd adds random en gaps and random ready, else ready is rd/rd_stop
   // and a fixed gap of gap_len cycles follows bit index gap_after.
   task automatic send(input logic [DW-1:0] w, input logic stop, input logic rd,
                       input logic rd_stop, input int gap_after, input int gap_len,
                       input bit rnd);
      logic [DW+1:0] bits;
      logic          r_now;
      bits = {1'b1, w, stop};
      for (int k = 0; k < DW + 2; k++) begin
         if (rnd && ($urandom_range(0, 3) == 0)) begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++)
               step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
         end
         r_now = rnd ? 1'($urandom_range(0, 1)) : ((k == DW + 1) ? rd_stop : rd);
         step(1'b0, bits[DW+1-k], 1'b1, r_now);
         if (k == gap_after) begin
            for (int g = 0; g < gap_len; g++)
               step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rd);
         end
      end
   endtask

   task automatic idle(input int n, input logic rd);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, rd);
   endtask

   initial begin
      rst = 1'b1; d = 1'b0; en = 1'b0; ready = 1'b0;

      // Reset and idle line
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_data",  32'(data_out), 32'(0));
      check("rst_valid", 32'(valid),    32'(0));
      idle(20, 1'b0);

      // Good frame 0xA5 held, then consumed
      send(8'hA5, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
      check("a5_data",  32'(data_out), 32'h0000_00A5);
      check("a5_valid", 32'(valid),    32'(1));
      idle(5, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("a5_consumed", 32'(valid), 32'(0));

      // Framing error then good 0x3C
      send(8'hFF, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
      check("ferr_pulse", 32'(frame_err), 32'(1));
      idle(1, 1'b0);
      send(8'h3C, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
      check("3c_data", 32'(data_out), 32'h0000_003C);
      idle(1, 1'b1);

      // Overrun, then back-to-back accepted on the stop edge
      send(8'h11, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
      send(8'h22, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
      check("ovr_pulse", 32'(overrun),  32'(1));
      check("ovr_keep",  32'(data_out), 32'h0000_0011);
      idle(2, 1'b0);
      send(8'h22, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
      check("b2b_valid", 32'(valid),    32'(1));
      check("b2b_data",  32'(data_out), 32'h0000_0022);
      idle(1, 1'b1);

      // en gap of 3 cycles after data bit 4 of 0xC3
      send(8'hC3, 1'b0, 1'b0, 1'b0, 4, 3, 1'b0);
      check("gap_data", 32'(data_out), 32'h0000_00C3);
      idle(1, 1'b1);

      // Reset after data bit 5, then 0x5A
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      send(8'h5A, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
      check("rst_mid_data", 32'(data_out), 32'h0000_005A);
      idle(1, 1'b1);

      // Randomized frames, gaps, ready and idle stretches
      for (int f = 0; f < 60; f++) begin
         send(8'($urandom), 1'($urandom_range(0, 9) == 0), 1'b0, 1'b0, -1, 0, 1'b1);
         for (int i = 0; i < int'($urandom_range(0, 3)); i++)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(3, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
